covid_drip_scheduler: RTL and testbench
=======================================

Name: covid_drip_scheduler

Overview:
- Upstream stage of the per-object covid trajectory blocks. Decides when the enemy releases a covid drip and which slot (one covidLogic instance per slot) gets it.
- Latches the enemy position at release and holds the per-slot dripStart level. Converts per-slot terminate events into one-cycle covidDisapper pulses.
- Tracks slot occupancy for one level; slots are one-shot per level.

Parameters:
- NUM_SLOTS, 4, number of covid object instances driven (1..8).
- DRIP_PERIOD_FRAMES, 45, frames between releases (1..255).
- MAX_ACTIVE, 2, maximum slots simultaneously ARMED (1..NUM_SLOTS).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- gameActive  in  1  level running; low freezes scheduling.
- levelStart  in  1  one-cycle pulse; re-initialises scheduler for a new level.
- enemyTopLeftX  in  11  current enemy X.
- enemyTopLeftY  in  11  current enemy Y.
- slotHit  in  NUM_SLOTS  per-slot terminate event (collision or floor), pulse or level.
- dripStart  out  NUM_SLOTS  per-slot level; high from release until slot retires.
- covidDisapper  out  NUM_SLOTS  one-cycle pulse when an ARMED slot retires.
- launchX  out  11  enemy X latched at last release; feeds all slots' enemyTopLeftX.
- launchY  out  11  enemy Y latched at last release; feeds all slots' enemyTopLeftY.
- activeCount  out  4  number of ARMED slots.
- allSpent  out  1  high when no FREE slots remain and activeCount is 0.

Behaviour:
- Reset values:
  - dripStart=0, covidDisapper=0, launchX=0, launchY=0, activeCount=0, allSpent=0.
  - Scheduler FSM in IDLE, frame counter 0, all slots FREE.
- Slot states: FREE -> ARMED -> DONE.
  - A DONE slot returns to FREE only on levelStart or reset.
- Scheduler states:
  - IDLE: entered on reset or levelStart. Moves to WAIT when gameActive is high.
  - WAIT: frameCnt increments on each startOfFrame. When frameCnt reaches DRIP_PERIOD_FRAMES-1 on a startOfFrame, go to LAUNCH if a FREE slot exists and activeCount<MAX_ACTIVE. Otherwise saturate frameCnt at the period and stall until both conditions hold; the check is made every cycle, not only on startOfFrame.
  - LAUNCH: lasts one cycle.
    - Select the lowest-index FREE slot.
    - Set launchX/launchY from enemyTopLeftX/Y.
    - Set dripStart[slot]=1 on the same edge; the slot becomes ARMED.
    - Clear frameCnt.
    - Next state is EXHAUSTED if no FREE slot remains, else WAIT.
  - EXHAUSTED: no further releases. allSpent=1 once activeCount==0.
- launchX/launchY change only in LAUNCH, so they are stable whenever a newly raised dripStart is first sampled downstream.
- Retirement: slotHit[i] while slot i is ARMED, on the next edge:
  - dripStart[i]=0, slot i becomes DONE.
  - covidDisapper[i]=1 for exactly one cycle.
- slotHit on a FREE or DONE slot is ignored; no pulse.
- Holding slotHit high produces only one pulse, because the slot leaves ARMED.
- Simultaneous events:
  - Retirement and LAUNCH in the same cycle: both take effect. activeCount reflects +1 and -1, net unchanged.
  - LAUNCH selects a slot whose slotHit is high in that cycle: the hit is ignored because the slot was FREE.
- gameActive low: frameCnt frozen, no LAUNCH, retirements still processed. If it drops during WAIT, the FSM stays in WAIT.
- levelStart:
  - Priority over all except reset.
  - All slots FREE, dripStart=0, covidDisapper=0, frameCnt=0, go to IDLE.
  - launchX/launchY keep their values.
- activeCount is registered and equals the popcount of ARMED slots. Width 4 covers NUM_SLOTS up to 8.
- Arithmetic: frameCnt is 8 bits unsigned and never wraps (saturating compare).

Optional Feature:
- Macro COVID_DRIP_JITTER_EN.
- When defined:
  - An 8-bit maximal LFSR (taps 8,6,5,4, seed 8'hA5 at reset) advances once per LAUNCH.
  - The effective period for the next release is DRIP_PERIOD_FRAMES + lfsr[3:0], so 0..15 extra frames.
  - The compare target is registered at LAUNCH.
  - levelStart does not reseed the LFSR.
- When undefined: fixed period DRIP_PERIOD_FRAMES, no LFSR logic.

Decomposition:
- Package covid_pkg holds:
  - slot_state_t enum {FREE, ARMED, DONE}.
  - sched_state_t enum {IDLE, WAIT, LAUNCH, EXHAUSTED}.
  - Constants COORD_W=11, FRAME_CNT_W=8, LFSR_SEED=8'hA5.
- One sub-module, covid_drip_lfsr: 8-bit LFSR with advance strobe. Instantiated only under COVID_DRIP_JITTER_EN.

Test Plan:
- Basic release: reset, gameActive=1, enemy=(200,40), 45 startOfFrame pulses -> dripStart=4'b0001 one cycle after the 45th pulse, launchX=200, launchY=40, activeCount=1.
- Cap stall (MAX_ACTIVE=2):
  - No hits, 135 frames -> only slots 0 and 1 armed; frameCnt stays saturated.
  - Then slotHit[0] -> covidDisapper=4'b0001 for 1 cycle, dripStart[2] rises within 2 cycles.
- Exhaustion: release 4 drips, hitting each after launch -> FSM in EXHAUSTED; allSpent=1 after the last retirement; no further dripStart over 200 frames.
- Spurious hits: slotHit=4'b1111 held 10 cycles with only slot 0 ARMED -> exactly one covidDisapper pulse on bit 0 only; slots 1-3 remain FREE.
- Simultaneous events and levelStart:
  - slotHit[0] coincident with LAUNCH cycle for slot 1 -> activeCount unchanged.
  - levelStart mid-WAIT with frameCnt=30 -> dripStart=0, all slots FREE, next release 45 frames after gameActive.
- Jitter (with COVID_DRIP_JITTER_EN): first release at 45+lfsr[3:0] frames, computed from 8'hA5 sequence and matched by the bench model; without the macro, exactly 45 frames.

Source files
------------

// File: rtl/covid_pkg.sv
// Shared types and constants for the covid drip scheduler and its LFSR.
package covid_pkg;

  localparam int COORD_W     = 11;
  localparam int FRAME_CNT_W = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {FREE, ARMED, DONE} slot_state_t;
  typedef enum logic [1:0] {IDLE, WAIT, LAUNCH, EXHAUSTED} sched_state_t;

  // Maximal-length 8-bit Fibonacci step, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/covid_drip_lfsr.sv
// 8-bit LFSR that advances once per strobe; used only for release-period jitter.
module covid_drip_lfsr
  import covid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      value <= LFSR_SEED;
    else if (advance)
      value <= lfsr_step(value);
  end

endmodule

// File: rtl/covid_drip_scheduler.sv
// Decides when the enemy drops a covid drip and which slot receives it.
// Optional release-period jitter is enabled by defining COVID_DRIP_JITTER_EN.
module covid_drip_scheduler
  import covid_pkg::*;
#(
  parameter int NUM_SLOTS          = 4,
  parameter int DRIP_PERIOD_FRAMES = 45,
  parameter int MAX_ACTIVE         = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 gameActive,
  input  logic                 levelStart,
  input  logic [COORD_W-1:0]   enemyTopLeftX,
  input  logic [COORD_W-1:0]   enemyTopLeftY,
  input  logic [NUM_SLOTS-1:0] slotHit,
  output logic [NUM_SLOTS-1:0] dripStart,
  output logic [NUM_SLOTS-1:0] covidDisapper,
  output logic [COORD_W-1:0]   launchX,
  output logic [COORD_W-1:0]   launchY,
  output logic [3:0]           activeCount,
  output logic                 allSpent
);

  sched_state_t state, state_next;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_next, target;
  slot_state_t slot_q [NUM_SLOTS];
  slot_state_t slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_mask, launch_onehot, retire, armed_next;
  logic [3:0] active_next;
  logic launch_fire, launch_take, found, due, can_launch, last_free;

  assign launch_take = launch_fire & ~levelStart;

`ifdef COVID_DRIP_JITTER_EN
  logic [7:0] lfsr_value;

  covid_drip_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (launch_take),
    .value   (lfsr_value)
  );

  function automatic logic [FRAME_CNT_W-1:0] jitter_target(input logic [7:0] r);
    logic [8:0] sum;
    sum = 9'(DRIP_PERIOD_FRAMES) + {5'd0, r[3:0]};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Target always tracks the current LFSR value, so it is reloaded with the advanced one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      target <= jitter_target(LFSR_SEED);
    else if (launch_take)
      target <= jitter_target(lfsr_step(lfsr_value));
  end
`else
  assign target = FRAME_CNT_W'(DRIP_PERIOD_FRAMES);
`endif

  always_comb begin
    free_mask     = '0;
    launch_onehot = '0;
    found         = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_mask[i] = (slot_q[i] == FREE);
      if (free_mask[i] && !found) begin
        launch_onehot[i] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  assign last_free  = ((free_mask & ~launch_onehot) == '0);
  assign can_launch = (|free_mask) && (activeCount < 4'(MAX_ACTIVE));
  // The counter saturates at the target, so ">=" keeps a stalled release pending.
  assign due = (frame_cnt >= target) ||
               (startOfFrame && (frame_cnt == target - 8'd1));

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    launch_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (gameActive)
          state_next = WAIT;
      end
      WAIT: begin
        if (gameActive) begin
          if (startOfFrame && (frame_cnt < target))
            frame_cnt_next = frame_cnt + 8'd1;
          if (due && can_launch)
            state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        launch_fire    = 1'b1;
        frame_cnt_next = '0;
        state_next     = last_free ? EXHAUSTED : WAIT;
      end
      EXHAUSTED: begin
        state_next = EXHAUSTED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else if (levelStart) begin
      state     <= IDLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  // Retirement is checked before launch; a slot being launched is FREE, so its hit is ignored.
  always_comb begin
    retire      = '0;
    armed_next  = '0;
    active_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (slot_q[i] == ARMED && slotHit[i]) begin
        slot_d[i] = DONE;
        retire[i] = 1'b1;
      end else if (launch_fire && launch_onehot[i]) begin
        slot_d[i] = ARMED;
      end
      armed_next[i] = (slot_d[i] == ARMED);
      active_next   = active_next + {3'd0, armed_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        slot_q[i] <= FREE;
      dripStart     <= '0;
      covidDisapper <= '0;
      activeCount   <= '0;
      launchX       <= '0;
      launchY       <= '0;
    end else if (levelStart) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        slot_q[i] <= FREE;
      dripStart     <= '0;
      covidDisapper <= '0;
      activeCount   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++)
        slot_q[i] <= slot_d[i];
      dripStart     <= armed_next;
      covidDisapper <= retire;
      activeCount   <= active_next;
      if (launch_fire) begin
        launchX <= enemyTopLeftX;
        launchY <= enemyTopLeftY;
      end
    end
  end

  assign allSpent = (free_mask == '0) && (activeCount == 4'd0);

endmodule

// File: tb/tb_covid_drip_scheduler.sv
// Self-checking bench for covid_drip_scheduler: per-cycle model comparison plus directed literal checks.
module tb_covid_drip_scheduler;

  localparam int P    = 45;
  localparam int MAXA = 2;
  localparam int NS   = 4;
  localparam int S_FREE = 0, S_ARMED = 1, S_DONE = 2;
  localparam int PH_IDLE = 0, PH_COUNT = 1, PH_LAUNCH = 2, PH_EXH = 3;

  logic clk = 1'b0;
  logic reset, startOfFrame, gameActive, levelStart;
  logic [10:0] enemyX, enemyY;
  logic [3:0] slotHit;
  logic [3:0] dripStart, covidDisapper;
  logic [10:0] launchX, launchY;
  logic [3:0] activeCount;
  logic allSpent;

  int testsRun = 0;
  int testsFailed = 0;

  covid_drip_scheduler #(
    .NUM_SLOTS(NS), .DRIP_PERIOD_FRAMES(P), .MAX_ACTIVE(MAXA)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameActive(gameActive),
    .levelStart(levelStart), .enemyTopLeftX(enemyX), .enemyTopLeftY(enemyY),
    .slotHit(slotHit), .dripStart(dripStart), .covidDisapper(covidDisapper),
    .launchX(launchX), .launchY(launchY), .activeCount(activeCount), .allSpent(allSpent)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: slot occupancy plus "frames elapsed since last release".
  int m_slot [NS];
  int m_phase, m_frames, m_period, m_active;
  logic [3:0] m_drip, m_dis;
  logic [10:0] m_lx, m_ly;
`ifdef COVID_DRIP_JITTER_EN
  logic [7:0] m_lfsr;

  function automatic int jitterPeriod(input logic [7:0] r);
    int p;
    p = P + int'(r[3:0]);
    return (p > 255) ? 255 : p;
  endfunction
`endif

  task automatic initModel();
    for (int i = 0; i < NS; i++) m_slot[i] = S_FREE;
    m_phase = PH_IDLE; m_frames = 0; m_active = 0;
    m_drip = '0; m_dis = '0; m_lx = '0; m_ly = '0;
`ifdef COVID_DRIP_JITTER_EN
    m_lfsr = 8'hA5;
    m_period = jitterPeriod(m_lfsr);
`else
    m_period = P;
`endif
  endtask

  task automatic stepModel();
    int armedBefore, pick;
    bit anyFree, freeLeft;
    armedBefore = 0; anyFree = 0; pick = -1; freeLeft = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_slot[i] == S_ARMED) armedBefore++;
      if (m_slot[i] == S_FREE) anyFree = 1;
    end
    m_dis = '0;
    if (levelStart) begin
      for (int i = 0; i < NS; i++) m_slot[i] = S_FREE;
      m_frames = 0;
      m_phase = PH_IDLE;
    end else begin
      for (int i = 0; i < NS; i++)
        if (m_slot[i] == S_ARMED && slotHit[i]) begin
          m_slot[i] = S_DONE;
          m_dis[i] = 1'b1;
        end
      if (m_phase == PH_LAUNCH) begin
        for (int i = 0; i < NS; i++)
          if (pick < 0 && m_slot[i] == S_FREE) pick = i;
        m_slot[pick] = S_ARMED;
        m_lx = enemyX; m_ly = enemyY;
        m_frames = 0;
        for (int i = 0; i < NS; i++)
          if (m_slot[i] == S_FREE) freeLeft = 1;
        m_phase = freeLeft ? PH_COUNT : PH_EXH;
`ifdef COVID_DRIP_JITTER_EN
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_period = jitterPeriod(m_lfsr);
`endif
      end else if (m_phase == PH_COUNT && gameActive) begin
        if (startOfFrame && m_frames < m_period) m_frames++;
        if (m_frames >= m_period && anyFree && armedBefore < MAXA) m_phase = PH_LAUNCH;
      end else if (m_phase == PH_IDLE && gameActive) begin
        m_phase = PH_COUNT;
      end
    end
    m_active = 0;
    for (int i = 0; i < NS; i++) begin
      m_drip[i] = (m_slot[i] == S_ARMED);
      if (m_slot[i] == S_ARMED) m_active++;
    end
  endtask

  // Compare at the falling edge, then advance the model with the inputs the next rising edge will see.
  always @(negedge clk) begin
    if (reset) begin
      initModel();
    end else begin
      checkOutput("cyc_dripStart", 32'(dripStart), 32'(m_drip));
      checkOutput("cyc_covidDisapper", 32'(covidDisapper), 32'(m_dis));
      checkOutput("cyc_launchX", 32'(launchX), 32'(m_lx));
      checkOutput("cyc_launchY", 32'(launchY), 32'(m_ly));
      checkOutput("cyc_activeCount", 32'(activeCount), 32'(m_active));
      checkOutput("cyc_allSpent", 32'(allSpent), 32'((m_active == 0) && !(m_slot[0] == S_FREE ||
                  m_slot[1] == S_FREE || m_slot[2] == S_FREE || m_slot[3] == S_FREE)));
      stepModel();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic applyStimulus(input int frames);
    for (int f = 0; f < frames; f++) sendFrame();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    logic [3:0] pulseBits;
    reset = 1'b1; startOfFrame = 1'b0; gameActive = 1'b0; levelStart = 1'b0;
    enemyX = 11'd0; enemyY = 11'd0; slotHit = '0;
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_dripStart", 32'(dripStart), 32'd0);
    checkOutput("rst_covidDisapper", 32'(covidDisapper), 32'd0);
    checkOutput("rst_launchX", 32'(launchX), 32'd0);
    checkOutput("rst_activeCount", 32'(activeCount), 32'd0);
    checkOutput("rst_allSpent", 32'(allSpent), 32'd0);

    // Basic release on the period-th frame pulse
    gameActive = 1'b1; enemyX = 11'd200; enemyY = 11'd40;
    tick();
    applyStimulus(m_period - 1);
    checkOutput("basic_before", 32'(dripStart), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOutput("basic_launch_cycle", 32'(dripStart), 32'd0);
    tick();
    checkOutput("basic_dripStart", 32'(dripStart), 32'b0001);
    checkOutput("basic_launchX", 32'(launchX), 32'd200);
    checkOutput("basic_launchY", 32'(launchY), 32'd40);
    checkOutput("basic_activeCount", 32'(activeCount), 32'd1);
    tick();

    // Cap stall: two armed, third release waits for a retirement
    enemyX = 11'd300; enemyY = 11'd50;
    applyStimulus(m_period);
    applyStimulus(m_period);
    checkOutput("cap_dripStart", 32'(dripStart), 32'b0011);
    checkOutput("cap_activeCount", 32'(activeCount), 32'd2);
    checkOutput("cap_launchX", 32'(launchX), 32'd300);
    enemyX = 11'd400; enemyY = 11'd60;
    slotHit = 4'b0001;
    tick();
    slotHit = 4'b0000;
    checkOutput("cap_disapper", 32'(covidDisapper), 32'b0001);
    checkOutput("cap_after_hit_drip", 32'(dripStart), 32'b0010);
    tick();
    checkOutput("cap_disapper_once", 32'(covidDisapper), 32'd0);
    tick();
    checkOutput("cap_slot2_drip", 32'(dripStart), 32'b0110);
    checkOutput("cap_slot2_launchX", 32'(launchX), 32'd400);

    // Exhaustion: last slot released, then all retire
    enemyX = 11'd500; enemyY = 11'd70;
    slotHit = 4'b0010;
    tick();
    slotHit = 4'b0000;
    applyStimulus(m_period);
    checkOutput("exh_dripStart", 32'(dripStart), 32'b1100);
    checkOutput("exh_launchX", 32'(launchX), 32'd500);
    slotHit = 4'b0100;
    tick();
    slotHit = 4'b0000;
    checkOutput("exh_allSpent_pending", 32'(allSpent), 32'd0);
    slotHit = 4'b1000;
    tick();
    slotHit = 4'b0000;
    checkOutput("exh_last_disapper", 32'(covidDisapper), 32'b1000);
    checkOutput("exh_allSpent", 32'(allSpent), 32'd1);
    applyStimulus(200);
    checkOutput("exh_no_release", 32'(dripStart), 32'd0);
    checkOutput("exh_allSpent_hold", 32'(allSpent), 32'd1);

    // Spurious hits: only the armed slot retires, once
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    checkOutput("lvl_allSpent", 32'(allSpent), 32'd0);
    checkOutput("lvl_launchX_kept", 32'(launchX), 32'd500);
    tick();
    applyStimulus(m_period);
    checkOutput("spur_armed", 32'(dripStart), 32'b0001);
    pulses = 0; pulseBits = '0;
    slotHit = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (covidDisapper != 4'b0000) pulses++;
      pulseBits = pulseBits | covidDisapper;
    end
    slotHit = 4'b0000;
    checkOutput("spur_pulse_count", 32'(pulses), 32'd1);
    checkOutput("spur_pulse_bits", 32'(pulseBits), 32'b0001);
    applyStimulus(m_period);
    checkOutput("spur_next_slot1", 32'(dripStart), 32'b0010);

    // Retirement coincident with LAUNCH; hit on the slot being launched is ignored
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    tick();
    applyStimulus(m_period);
    applyStimulus(m_period - 1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    slotHit = 4'b0011;
    tick();
    slotHit = 4'b0000;
    checkOutput("sim_activeCount", 32'(activeCount), 32'd1);
    checkOutput("sim_dripStart", 32'(dripStart), 32'b0010);
    checkOutput("sim_disapper", 32'(covidDisapper), 32'b0001);
    tick();

    // levelStart mid-count, restart only once gameActive returns
    applyStimulus(30);
    gameActive = 1'b0;
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    checkOutput("mid_dripStart", 32'(dripStart), 32'd0);
    checkOutput("mid_activeCount", 32'(activeCount), 32'd0);
    applyStimulus(5);
    gameActive = 1'b1;
    tick();
    applyStimulus(m_period - 1);
    checkOutput("mid_not_yet", 32'(dripStart), 32'd0);
    sendFrame();
    checkOutput("mid_release", 32'(dripStart), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
